huff_burst_buffer: RTL
======================

HUFF_BURST_BUFFER -- requirements
Module: huff_burst_buffer

Interface
REQ-001 Parameter W, default 8: data width per channel.
REQ-002 Parameter CH, default 8: number of channels.
REQ-003 Parameter DEPTH, default 16: entries per channel FIFO; power of two, at least 2. AW = log2(DEPTH).
REQ-004 Parameter BURST, default 8: beats per lockstep burst; 1 <= BURST <= DEPTH.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 wr_en  input  CH  per-channel write strobe from the Huffman encoders.
REQ-008 wr_data  input  CH*W  channel j occupies bits [j*W +: W].
REQ-009 full  output  CH  channel occupancy equals DEPTH; combinational from the count.
REQ-010 flush  input  1  single-cycle request to drain all residual data.
REQ-011 rd_ready  input  1  downstream grant; a pop occurs only in a granted cycle.
REQ-012 d_out  output  CH*W  registered popped data, channel j at [j*W +: W].
REQ-013 en_out  output  CH  registered per-channel valid for d_out.
REQ-014 busy  output  1  high while the FSM is in BURST or FLUSH.
REQ-015 ovf  output  CH  sticky per-channel overflow flag.
REQ-016 level  output  CH*(AW+1)  per-channel occupancy count, channel j at [j*(AW+1) +: AW+1].

Function
REQ-017 Each channel is a circular FIFO with AW-bit write and read pointers that wrap naturally at DEPTH, plus an (AW+1)-bit count.
REQ-018 A write occurs when wr_en[j]=1 and count<DEPTH; the count increments unless that channel pops in the same cycle, in which case the count is unchanged.
REQ-019 A write to a full channel is dropped and sets ovf[j], even if that channel pops in the same cycle; ovf clears only on rst.
REQ-020 FSM states: IDLE, BURST, FLUSH.
REQ-021 IDLE -> BURST when every channel count >= BURST; beat counter loads BURST. This test has priority over a pending flush.
REQ-022 IDLE -> FLUSH when flush_pend=1 and the BURST condition is false.
REQ-023 flush_pend is set by flush=1 in any state and cleared on entry to FLUSH.
REQ-024 BURST: each cycle with rd_ready=1 pops one entry from every channel and decrements the beat counter. The state returns to IDLE after the pop that takes the counter to 0.
REQ-025 FLUSH: each cycle with rd_ready=1 pops one entry from each non-empty channel only. The state returns to IDLE in the cycle after all counts reach 0, counting writes made during FLUSH.
REQ-026 FLUSH entered with all channels empty returns to IDLE on the next cycle with no output.
REQ-027 A cycle with rd_ready=0 performs no pop, holds the state and beat counter, and drives en_out to 0 on the next cycle.
REQ-028 Output latency is one cycle: d_out[j] and en_out[j]=1 appear the cycle after the pop of channel j. Non-popping channels give en_out[j]=0, with d_out[j] holding its previous value.
REQ-029 Downstream must accept every beat with en_out asserted; the block does not retry.
REQ-030 busy = (state != IDLE), registered with the state.
REQ-031 In BURST, every channel is guaranteed non-empty for each remaining beat; an underflow in BURST is an assertion failure.

Reset
REQ-032 When rst=1 at a clock edge, the following clear: state to IDLE, pointers and counts to 0, beat counter to 0, flush_pend to 0, ovf to 0, en_out to 0, d_out to 0. full=0 and level=0 then follow from the cleared counts.
REQ-033 Reset mid-burst or mid-flush discards all buffered data; writes presented during the reset cycle are ignored.
REQ-034 Storage arrays need no reset.

Verification
REQ-035 CH=2, DEPTH=4, BURST=2, rd_ready=1. Write two entries, 0x11 then 0x12, to ch0 and 0x21, 0x22 to ch1. Required: busy rises; two beats {0x21,0x11} then {0x22,0x12}; en_out=2'b11 on each beat; then IDLE.
REQ-036 Same setup. Write one entry, 0xA1, to ch0 only, then pulse flush. Required: one beat with en_out=2'b01 and d_out[ch0]=0xA1; then IDLE with level=0.
REQ-037 Fill ch0 with 4 entries, then write a 5th. Required: full[0]=1; 5th entry dropped; ovf[0]=1 and stays set; flush returns exactly the first 4 values in order.
REQ-038 During BURST, hold rd_ready=0 for 3 cycles. Required: en_out=0 for those cycles; beat counter frozen; all burst beats delivered afterwards, none lost or duplicated.
REQ-039 Pulse flush during BURST. Required: the burst completes first, then FLUSH drains the residue.
REQ-040 Assert rst mid-FLUSH. Required: next cycle busy=0, en_out=0, level=0, ovf=0. Exercise pointer wrap by writing and popping 3*DEPTH entries and checking data order.

Source files
------------

// File: rtl/huff_burst_buffer.sv
// ---------------------------------------------------------------------------
// huff_burst_buffer
//
// Gathers the output of CH parallel Huffman encoders into one circular FIFO
// per channel. It releases the data downstream as lockstep bursts of BURST
// beats. A burst starts once every channel holds at least BURST entries.
// A flush request drains whatever residue is left. Each channel pops only
// while it holds data, and only in cycles granted by rd_ready.
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous reset, active-high
//   wr_en     [CH]          per-channel write strobe
//   wr_data   [CH*W]        write data, channel j at [j*W +: W]
//   full      [CH]          channel occupancy == DEPTH (combinational)
//   flush     1             single-cycle request to drain all residue
//   rd_ready  1             downstream grant, pops happen only when high
//   d_out     [CH*W]        registered popped data, channel j at [j*W +: W]
//   en_out    [CH]          registered per-channel valid for d_out
//   busy      1             FSM is in BURST or FLUSH
//   ovf       [CH]          sticky per-channel overflow flag
//   level     [CH*(AW+1)]   per-channel occupancy, channel j at [j*(AW+1) +: AW+1]
// ---------------------------------------------------------------------------
module huff_burst_buffer #(
  parameter int W     = 8,
  parameter int CH    = 8,
  parameter int DEPTH = 16,
  parameter int BURST = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       wr_en,
  input  logic [CH*W-1:0]     wr_data,
  output logic [CH-1:0]       full,
  input  logic                flush,
  input  logic                rd_ready,
  output logic [CH*W-1:0]     d_out,
  output logic [CH-1:0]       en_out,
  output logic                busy,
  output logic [CH-1:0]       ovf,
  output logic [CH*(AW+1)-1:0] level
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [AW:0] ZERO_L  = (AW+1)'(0);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_L = (AW+1)'(BURST);

  // FSM and control state
  logic [1:0]     state_q, state_d;
  logic [AW:0]    beat_q, beat_d;
  logic           flush_pend_q, flush_pend_d;
  logic           busy_q;

  // Per-channel FIFO state
  logic [AW-1:0]  wptr_q  [CH];
  logic [AW-1:0]  wptr_d  [CH];
  logic [AW-1:0]  rptr_q  [CH];
  logic [AW-1:0]  rptr_d  [CH];
  logic [AW:0]    count_q [CH];
  logic [AW:0]    count_d [CH];
  logic [W-1:0]   mem_q   [CH][DEPTH];

  logic [CH-1:0]  ovf_q, ovf_d;
  logic [CH-1:0]  en_out_q;
  logic [CH*W-1:0] d_out_q;

  // Decoded per-channel status
  logic [CH-1:0]  full_s;
  logic [CH-1:0]  nonempty_s;
  logic [CH-1:0]  wr_ok_s;
  logic [CH-1:0]  pop_s;
  logic           all_ge_burst_s;
  logic           any_nonempty_s;

  // Occupancy decode: full/non-empty flags and the burst-start condition
  always_comb begin
    full_s         = '0;
    nonempty_s     = '0;
    all_ge_burst_s = 1'b1;
    any_nonempty_s = 1'b0;
    for (int j = 0; j < CH; j++) begin
      full_s[j]      = (count_q[j] == DEPTH_L);
      nonempty_s[j]  = (count_q[j] != ZERO_L);
      all_ge_burst_s = all_ge_burst_s & (count_q[j] >= BURST_L);
      any_nonempty_s = any_nonempty_s | nonempty_s[j];
    end
  end

  // FSM next state, beat counter, flush latch and pop selection
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q | flush;
    pop_s        = '0;
    case (state_q)
      S_IDLE: begin
        // A ready burst wins over a pending flush
        if (all_ge_burst_s) begin
          state_d = S_BURST;
          beat_d  = BURST_L;
        end else if (flush_pend_q) begin
          state_d      = S_FLUSH;
          flush_pend_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (rd_ready) begin
          // Every channel is non-empty here; gating keeps pointers sane anyway
          pop_s  = nonempty_s;
          beat_d = beat_q - ONE_L;
          if (beat_q == ONE_L) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_BURST;
          end
        end else begin
          state_d = S_BURST;
        end
      end
      S_FLUSH: begin
        // Exit is judged on the registered counts, so late writes extend the drain
        if (!any_nonempty_s) begin
          state_d = S_IDLE;
        end else if (rd_ready) begin
          pop_s = nonempty_s;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = ZERO_L;
      end
    endcase
  end

  // FIFO pointer/count next state and overflow detection
  always_comb begin
    wr_ok_s = '0;
    ovf_d   = ovf_q;
    for (int j = 0; j < CH; j++) begin
      wptr_d[j]  = wptr_q[j];
      rptr_d[j]  = rptr_q[j];
      count_d[j] = count_q[j];
      // A write to a full channel is dropped even if it pops this cycle
      wr_ok_s[j] = wr_en[j] & ~full_s[j];
      ovf_d[j]   = ovf_q[j] | (wr_en[j] & full_s[j]);
      if (wr_ok_s[j]) begin
        wptr_d[j] = wptr_q[j] + AW'(1);
      end else begin
        wptr_d[j] = wptr_q[j];
      end
      if (pop_s[j]) begin
        rptr_d[j] = rptr_q[j] + AW'(1);
      end else begin
        rptr_d[j] = rptr_q[j];
      end
      case ({wr_ok_s[j], pop_s[j]})
        2'b10:   count_d[j] = count_q[j] + ONE_L;
        2'b01:   count_d[j] = count_q[j] - ONE_L;
        default: count_d[j] = count_q[j];
      endcase
    end
  end

  // Control and FIFO bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= ZERO_L;
      flush_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= '0;
      en_out_q     <= '0;
      for (int j = 0; j < CH; j++) begin
        wptr_q[j]  <= '0;
        rptr_q[j]  <= '0;
        count_q[j] <= ZERO_L;
      end
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      busy_q       <= (state_d != S_IDLE);
      ovf_q        <= ovf_d;
      en_out_q     <= pop_s;
      for (int j = 0; j < CH; j++) begin
        wptr_q[j]  <= wptr_d[j];
        rptr_q[j]  <= rptr_d[j];
        count_q[j] <= count_d[j];
      end
    end
  end

  // Output data register; non-popping channels hold their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q <= '0;
    end else begin
      for (int j = 0; j < CH; j++) begin
        if (pop_s[j]) begin
          d_out_q[j*W +: W] <= mem_q[j][rptr_q[j]];
        end else begin
          d_out_q[j*W +: W] <= d_out_q[j*W +: W];
        end
      end
    end
  end

  // Storage array, no reset needed since counts gate every read
  always_ff @(posedge clk) begin
    for (int j = 0; j < CH; j++) begin
      if (!rst && wr_ok_s[j]) begin
        mem_q[j][wptr_q[j]] <= wr_data[j*W +: W];
      end
    end
  end

  // Level vector packing
  always_comb begin
    level = '0;
    for (int j = 0; j < CH; j++) begin
      level[j*(AW+1) +: (AW+1)] = count_q[j];
    end
  end

  assign full   = full_s;
  assign d_out  = d_out_q;
  assign en_out = en_out_q;
  assign busy   = busy_q;
  assign ovf    = ovf_q;

  huff_burst_buffer_chk #(
    .CH (CH)
  ) u_chk (
    .clk        (clk),
    .rst_i      (rst),
    .in_burst_i (state_q == S_BURST),
    .rd_ready_i (rd_ready),
    .nonempty_i (nonempty_s)
  );

endmodule

// ---------------------------------------------------------------------------
// huff_burst_buffer_chk
//
// Protocol checker: a granted BURST cycle must find every channel non-empty.
//
// Ports
//   clk         clock
//   rst_i       synchronous reset, active-high
//   in_burst_i  FSM is in BURST
//   rd_ready_i  downstream grant
//   nonempty_i  [CH] per-channel non-empty flags
// ---------------------------------------------------------------------------
module huff_burst_buffer_chk #(
  parameter int CH = 8
) (
  input logic          clk,
  input logic          rst_i,
  input logic          in_burst_i,
  input logic          rd_ready_i,
  input logic [CH-1:0] nonempty_i
);

  // Underflow during a burst beat
  always @(posedge clk) begin
    assert (rst_i || !(in_burst_i && rd_ready_i) || (&nonempty_i));
  end

endmodule
